seq_multiplier: RTL and testbench



---
 rtl/seq_multiplier_pkg.sv | 36 +++
 rtl/seq_multiplier_if.sv | 27 ++
 rtl/seq_multiplier.sv | 105 ++++++++++
 tb/tb_seq_multiplier.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package seq_multiplier_pkg;

   // Widest operand the helpers below are sized for.
   localparam int MAX_W  = 16;
   localparam int MAX_PW = 2 * MAX_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Product width for a given operand width.
   function automatic int prod_w(input int w);
      return 2 * w;
   endfunction

   // Counter width able to hold the value w.
   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

   // Magnitude of a sign-extended two's complement value. The most negative
   // operand of any width <= MAX_W comes out as its positive unsigned value.
   function automatic logic [MAX_W-1:0] mag(input logic [MAX_W-1:0] v);
      return v[MAX_W-1] ? (~v + 1'b1) : v;
   endfunction

   // Conditionally negate a product in two's complement.
   function automatic logic [MAX_PW-1:0] apply_sign(input logic [MAX_PW-1:0] v,
                                                    input logic              neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Launch/result bus between the calculator control FSM and the multiplier.
interface seq_multiplier_if #(
   parameter int WIDTH = 4
) ();
   import seq_multiplier_pkg::*;

   localparam int PROD_W = prod_w(WIDTH);

   logic              start;
   logic              signed_mode;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              busy;
   logic              done;
   logic [PROD_W-1:0] product;

   modport master (
      output start, signed_mode, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, signed_mode, a, b,
      output busy, done, product
   );

endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit retired per clock,
// signed operands handled as sign-magnitude around an unsigned core.
module seq_multiplier
   import seq_multiplier_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   seq_multiplier_if.slave  bus
);

   localparam int PROD_W = prod_w(WIDTH);
   localparam int CNT_W  = cnt_w(WIDTH);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   // Upper half collects the partial product; lower half starts out holding
   // the multiplier magnitude, which is consumed LSB-first as product bits
   // shift in from above.
   logic [PROD_W-1:0] acc_q;
   logic [PROD_W-1:0] acc_d;
   logic [WIDTH-1:0]  mcand_q;
   logic              neg_q;
   logic              busy_q;
   logic              done_q;
   logic [PROD_W-1:0] product_q;
   logic [PROD_W-1:0] product_d;

   logic [WIDTH-1:0]  a_mag;
   logic [WIDTH-1:0]  b_mag;
   logic              neg_d;
   logic [WIDTH:0]    sum;

   // Operand conditioning at launch: magnitudes and result sign.
   always_comb begin
      a_mag = bus.a;
      b_mag = bus.b;
      neg_d = 1'b0;
      if (bus.signed_mode) begin
         a_mag = WIDTH'(mag(MAX_W'(signed'(bus.a))));
         b_mag = WIDTH'(mag(MAX_W'(signed'(bus.b))));
         neg_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      end
   end

   // One add-and-shift step; the carry out of the add becomes the new MSB.
   always_comb begin
      sum       = {1'b0, acc_q[PROD_W-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      acc_d     = {sum, acc_q[WIDTH-1:1]};
      product_d = PROD_W'(apply_sign(MAX_PW'(acc_d), neg_q));
   end

   // Control FSM with counter, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         neg_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         case (state_q)
            // DONE accepts a start exactly like IDLE, so back-to-back
            // operations run with no idle gap.
            IDLE, DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
               if (bus.start) begin
                  mcand_q <= a_mag;
                  acc_q   <= {{WIDTH{1'b0}}, b_mag};
                  neg_q   <= neg_d;
                  cnt_q   <= CNT_W'(WIDTH);
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            // Fixed WIDTH-cycle run; no early exit on zero operands.
            RUN: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  product_q <= product_d;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= DONE;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed WIDTH=4 cases plus randomized WIDTH=8
// traffic compared against a plain-arithmetic reference product.
module tb_seq_multiplier;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   seq_multiplier_if #(.WIDTH(4)) if4 ();
   seq_multiplier_if #(.WIDTH(8)) if8 ();

   seq_multiplier #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
   seq_multiplier #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

   int n_chk  = 0;
   int n_pass = 0;

   int   dbl_done  = 0;
   int   done8_cnt = 0;
   logic prev4     = 1'b0;
   logic prev8     = 1'b0;

   // Track back-to-back done pulses and total WIDTH=8 completions.
   always @(negedge clk) begin
      if ((if4.done && prev4) || (if8.done && prev8)) dbl_done <= dbl_done + 1;
      if (if8.done) done8_cnt <= done8_cnt + 1;
      prev4 <= if4.done;
      prev8 <= if8.done;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got %0d checks", n_chk);
      $fatal(1);
   end

   task automatic chk(input string tag, input longint unsigned got,
                      input longint unsigned exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference: true product of the operands as integers, kept modulo 2^(2w).
   function automatic longint unsigned ref_mul(input int w, input longint unsigned a,
                                               input longint unsigned b, input bit s);
      longint sa, sb, p;
      sa = longint'(a);
      sb = longint'(b);
      if (s && (((a >> (w - 1)) & 1) != 0)) sa = sa - (longint'(1) << w);
      if (s && (((b >> (w - 1)) & 1) != 0)) sb = sb - (longint'(1) << w);
      p = sa * sb;
      return longint'(p) & ((64'd1 << (2 * w)) - 1);
   endfunction

   function automatic logic [15:0] prod_of(input bit w8);
      return w8 ? if8.product : {8'h00, if4.product};
   endfunction

   function automatic logic busy_of(input bit w8);
      return w8 ? if8.busy : if4.busy;
   endfunction

   function automatic logic done_of(input bit w8);
      return w8 ? if8.done : if4.done;
   endfunction

   // Call at a negedge; returns just after the accepting edge.
   task automatic launch(input bit w8, input logic [7:0] a, input logic [7:0] b,
                         input bit s);
      if (w8) begin
         if8.a = a; if8.b = b; if8.signed_mode = s; if8.start = 1'b1;
      end else begin
         if4.a = a[3:0]; if4.b = b[3:0]; if4.signed_mode = s; if4.start = 1'b1;
      end
      @(posedge clk);
      #1;
      if4.start = 1'b0;
      if8.start = 1'b0;
   endtask

   // Counts edges from the accepting edge (inclusive) until done is seen.
   task automatic wait_done(input bit w8, output int edges, output int busy_cyc);
      edges    = 1;
      busy_cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done_of(w8)) return;
         if (busy_of(w8)) busy_cyc++;
         @(posedge clk);
         edges++;
      end
      edges = -1;
   endtask

   task automatic op(input string tag, input bit w8, input logic [7:0] a,
                     input logic [7:0] b, input bit s, input logic [15:0] exp);
      int e, bc;
      launch(w8, a, b, s);
      wait_done(w8, e, bc);
      chk({tag, "_prod"}, prod_of(w8), exp);
      chk({tag, "_lat"}, e, w8 ? 9 : 5);
      chk({tag, "_busycyc"}, bc, w8 ? 8 : 4);
      chk({tag, "_busy_in_done"}, busy_of(w8), 0);
   endtask

   initial begin
      int e, bc, cnt, chg;
      logic [7:0] ra, rb;
      bit rs;
      longint unsigned rexp;

      rst = 1'b1;
      if4.start = 0; if4.signed_mode = 0; if4.a = '0; if4.b = '0;
      if8.start = 0; if8.signed_mode = 0; if8.a = '0; if8.b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", if4.busy, 0);
      chk("rst_done", if4.done, 0);
      chk("rst_prod", if4.product, 0);
      chk("rst_prod8", if8.product, 0);

      // Unsigned and signed directed cases.
      op("u_15x15", 0, 8'd15, 8'd15, 0, 16'h00E1);
      @(negedge clk);
      chk("done_one_cycle", if4.done, 0);
      op("u_3x5", 0, 8'd3, 8'd5, 0, 16'h000F);
      @(negedge clk);
      op("s_m8x7", 0, 8'h8, 8'h7, 1, 16'h00C8);
      @(negedge clk);
      op("s_m8xm8", 0, 8'h8, 8'h8, 1, 16'h0040);
      @(negedge clk);
      op("s_m3x2", 0, 8'hD, 8'h2, 1, 16'h00FA);

      // Start and operand changes while busy are ignored.
      @(negedge clk);
      launch(0, 8'd6, 8'd7, 0);
      @(negedge clk);
      if4.a = 4'hF; if4.b = 4'hF; if4.signed_mode = 1'b1; if4.start = 1'b1;
      @(posedge clk);
      #1;
      if4.start = 1'b0;
      wait_done(0, e, bc);
      chk("busy_ign_prod", prod_of(0), 16'h002A);
      // two edges already consumed before wait_done started counting
      chk("busy_ign_lat", e, 4);

      // Back-to-back: second start lands in the done cycle.
      @(negedge clk);
      op("b2b_first", 0, 8'd5, 8'd5, 0, 16'h0019);
      op("b2b_second", 0, 8'h3, 8'hF, 1, 16'h00FD);

      // Reset two cycles into a run.
      @(negedge clk);
      launch(0, 8'd9, 8'd9, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_busy", if4.busy, 0);
      chk("rst_mid_done", if4.done, 0);
      chk("rst_mid_prod", if4.product, 0);
      rst = 1'b0;
      cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (if4.done) cnt++;
      end
      chk("rst_mid_no_done", cnt, 0);

      // Reset and start together: reset wins.
      rst = 1'b1;
      if4.a = 4'd3; if4.b = 4'd3; if4.signed_mode = 1'b0; if4.start = 1'b1;
      @(negedge clk);
      chk("rst_start_busy", if4.busy, 0);
      rst = 1'b0;
      if4.start = 1'b0;
      @(negedge clk);
      chk("rst_start_idle", if4.busy, 0);

      // Zero operand still takes the full latency.
      op("pre_zero", 0, 8'd3, 8'd5, 0, 16'h000F);
      @(negedge clk);
      op("zero_b", 0, 8'd0, 8'd9, 0, 16'h0000);

      // Product holds with start low while inputs wander.
      @(negedge clk);
      op("hold_op", 0, 8'd6, 8'd7, 0, 16'h002A);
      cnt = 0;
      chg = 0;
      repeat (20) begin
         @(negedge clk);
         if4.a = 4'($urandom);
         if4.b = 4'($urandom);
         if (if4.done) cnt++;
         if (if4.product != 8'h2A) chg++;
      end
      chk("hold_done", cnt, 0);
      chk("hold_prod_changes", chg, 0);

      // WIDTH=8 randomized, with corner operands first.
      for (int i = 0; i < 1000; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         case (i)
            0: begin ra = 8'h80; rb = 8'h80; rs = 1'b1; end
            1: begin ra = 8'hFF; rb = 8'hFF; rs = 1'b0; end
            2: begin ra = 8'h80; rb = 8'h7F; rs = 1'b1; end
            3: begin ra = 8'h00; rb = 8'h80; rs = 1'b1; end
            4: begin ra = 8'hFF; rb = 8'h01; rs = 1'b1; end
            default: ;
         endcase
         rexp = ref_mul(8, ra, rb, rs);
         if ($urandom_range(0, 3) != 0) @(negedge clk);
         op("rand8", 1, ra, rb, rs, 16'(rexp));
      end

      repeat (2) @(negedge clk);
      chk("done8_pulses", done8_cnt, 1000);
      chk("no_double_done", dbl_done, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
